// File: rtl/digital_fd_lock_if.sv
// digital_fd_lock_if: enable/feedback-phase inputs and frequency-detector outputs
interface digital_fd_lock_if;
   logic               en;
   logic [7:0]         fb_phase;
   logic               fup;
   logic               fdn;
   logic signed [16:0] freq_err;
   logic               win_done;
   logic               locked;
   modport master (output en, fb_phase, input fup, fdn, freq_err, win_done, locked);
   modport slave  (input en, fb_phase, output fup, fdn, freq_err, win_done, locked);
endinterface

// File: rtl/digital_fd_lock.sv
// digital_fd_lock: windowed feedback-edge counter with frequency-detector pulses and lock FSM
module digital_fd_lock #(
   parameter int N_DIV      = 32,
   parameter int WIN        = 16,
   parameter int TOL        = 2,
   parameter int UNLOCK_TOL = 8,
   parameter int LOCK_CNT   = 4
) (
   input logic              clk,
   input logic              reset,
   digital_fd_lock_if.slave bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] PRIME  = 2'd1;
   localparam logic [1:0] ACQ    = 2'd2;
   localparam logic [1:0] LOCKED = 2'd3;
   localparam logic signed [16:0] TGT  = 17'(N_DIV * WIN);
   localparam logic signed [16:0] TOLS = 17'(TOL);
   localparam logic signed [16:0] UTOL = 17'(UNLOCK_TOL);
   logic [1:0]         state;
   logic [7:0]         prev;
   logic [7:0]         delta;
   logic [15:0]        sum;
   logic [15:0]        sum_nxt;
   logic [7:0]         wcnt;
   logic [7:0]         lock_cnt;
   logic [7:0]         lock_nxt;
   logic signed [16:0] err;
   logic               win_end;
   logic               in_tol;
   logic               out_ul;
   // per-cycle edge delta (8-bit modulo makes phase wrap transparent) and window-end decisions
   always_comb begin
      delta    = bus.fb_phase - prev;
      sum_nxt  = sum + 16'(delta);
      err      = TGT - $signed({1'b0, sum_nxt});
      win_end  = wcnt == 8'(WIN - 1);
      in_tol   = err <= TOLS && err >= -TOLS;
      out_ul   = err > UTOL || err < -UTOL;
      lock_nxt = lock_cnt + 8'd1;
   end
   // lock FSM, window accumulation and one-cycle FD pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         prev         <= '0;
         sum          <= '0;
         wcnt         <= '0;
         lock_cnt     <= '0;
         bus.fup      <= 1'b0;
         bus.fdn      <= 1'b0;
         bus.win_done <= 1'b0;
         bus.locked   <= 1'b0;
         bus.freq_err <= '0;
      end else if (!bus.en) begin
         state        <= IDLE;
         sum          <= '0;
         wcnt         <= '0;
         lock_cnt     <= '0;
         bus.fup      <= 1'b0;
         bus.fdn      <= 1'b0;
         bus.win_done <= 1'b0;
         bus.locked   <= 1'b0;
      end else begin
         bus.fup      <= 1'b0;
         bus.fdn      <= 1'b0;
         bus.win_done <= 1'b0;
         case (state)
            IDLE: state <= PRIME;
            PRIME: begin
               prev  <= bus.fb_phase;
               sum   <= '0;
               wcnt  <= '0;
               state <= ACQ;
            end
            default: begin
               prev <= bus.fb_phase;
               sum  <= win_end ? '0 : sum_nxt;
               wcnt <= win_end ? '0 : wcnt + 8'd1;
               if (win_end) begin
                  bus.freq_err <= err;
                  bus.win_done <= 1'b1;
                  if (state == ACQ) begin
                     bus.fup  <= err > TOLS;
                     bus.fdn  <= err < -TOLS;
                     lock_cnt <= in_tol ? lock_nxt : '0;
                     if (in_tol && lock_nxt == 8'(LOCK_CNT)) begin
                        state      <= LOCKED;
                        bus.locked <= 1'b1;
                     end
                  end else if (out_ul) begin
                     bus.fup    <= err > 0;
                     bus.fdn    <= err < 0;
                     bus.locked <= 1'b0;
                     lock_cnt   <= '0;
                     state      <= ACQ;
                  end
               end
            end
         endcase
      end
   end
endmodule
